flit_queue_nc: RTL and testbench
================================

Name: flit_queue_nc

Overview:
Input unit of a DART network-simulator router: accepts flits addressed to this queue, stamps each with an arrival time (flit timestamp + configured link latency), and stores them in one FIFO per virtual channel (VC). A flit is presented on its VC's output once simulation time reaches its stamped time. Latency is loaded through a 16-bit daisy-chained config path and is also exported for the credit path.

Parameters:
HADDR, 11'd1, this queue's address (8-bit node ID, 3-bit port ID); flits are accepted only when nexthop_in equals it.
LOG_NVCS, 1, log2 of the VC count; NVCS = 2**LOG_NVCS.
LOG_DEP, 4, log2 of the per-VC FIFO depth (16 flits).

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
enable  in  1  global advance; gates all enqueue/dequeue
sim_time  in  TS_WIDTH(10)  current simulation time
error  out  1  protocol violation (combinational)
is_quiescent  out  1  all VC FIFOs empty
latency  out  LAT_WIDTH(8)  configured latency register
config_in  in  16  config word
config_in_valid  in  1  config word strobe
config_out  out  16  forwarded config word (registered)
config_out_valid  out  1  forwarded strobe (registered)
flit_full  out  NVCS  per-VC FIFO full
flit_in_valid  in  1  incoming flit valid
flit_in  in  FLIT_WIDTH(36)  flit: ts=[35:26], vc=[LOG_NVCS-1:0]
nexthop_in  in  A_WIDTH(11)  destination queue address
flit_ack  out  1  flit accepted this cycle
flit_out  out  NVCS*36  per-VC head flit, VC v at [36v+35:36v]
flit_out_valid  out  NVCS  per-VC ready
dequeue  in  NVCS  per-VC pop

Behaviour:
- Reset: FIFO pointers/counts = 0, latency = 0, config_out = 0, config_out_valid = 0, dequeue blackout flags = 0; hence flit_full = 0, flit_out_valid = 0, is_quiescent = 1.
- Config: on config_in_valid, latency <= config_in[7:0], config_out <= {8'b0, old latency}, config_out_valid <= 1. Otherwise config_out_valid <= 0 and config_out holds. Shift-chain semantics; independent of enable.
- Accept: vc = flit_in[LOG_NVCS-1:0]; match = (nexthop_in == HADDR); flit_ack = enable & flit_in_valid & match & ~flit_full[vc] (combinational). On ack, write flit with ts field replaced by (ts + latency) mod 2^10; other bits unchanged.
- FIFO (per VC): 2^LOG_DEP entries; flit_out is the head, read combinationally from RAM; full when count == depth; pops on enable & dequeue[v] & count != 0. Simultaneous push and pop is legal; count holds and pointers advance. A push is never acked when the FIFO is full, even if a pop occurs in the same cycle.
- Output ready (per VC): flit_out_valid[v] = (count != 0) & ~blk[v] & time_ok, where time_ok = ((sim_time - head_ts) mod 2^10) < 512 (wrap-safe "reached"). blk[v] <= enable & dequeue[v] for one cycle, giving at most one pop per 2 cycles per VC ("slow" FIFO).
- error = OR over v of (flit_in_valid & match & vc==v & flit_full[v]) | (dequeue[v] & count_v==0). An illegal pop does not change state.
- is_quiescent = AND of all (count_v == 0).
- enable=0: no push, no pop, no flit_ack; config path still operates.
- Reset asserted mid-operation discards all queued flits.

Optional Feature:
FLIT_QUEUE_TRACE_EN: when defined, the simulation-only block prints "T <sim_time> FQ (<HADDR>) enq vc <v> flit <f>" on each ack and "... deq vc <v>" on each pop. When undefined, no $display is compiled and the logic is identical.

Decomposition:
- Shared package dart_pkg: TS_WIDTH=10, LAT_WIDTH=8, A_WIDTH=11, FLIT_WIDTH=36, flit field positions, and functions flit_ts(f), flit_vc(f), update_flit_ts(f, ts).
- One sub-module ram_fifo_slow (WIDTH, LOG_DEP; ports write/read/full/empty/data_out, with the blackout flag inside), instantiated NVCS times via generate.

Test Plan:
- Reset, then config_in=16'h0005 with valid: latency=5, config_out=16'h0000 with valid=1 one cycle later; a second word 16'h0009 gives config_out=16'h0005.
- latency=5, sim_time=10, flit ts=10, vc=1, nexthop=HADDR: flit_ack=1; flit_out_valid[1]=0 until sim_time=15, then 1 with ts field=15.
- nexthop != HADDR: flit_ack=0, no state change, error=0.
- Fill VC0 with 16 flits: flit_full[0]=1; a 17th valid matching flit gives flit_ack=0, error=1.
- Wrap: latency=10, ts=1020 gives stored ts=6; with sim_time=1022 valid=0, with sim_time=6 valid=1.
- dequeue[0] on empty VC0 gives error=1; back-to-back pops give valid low the cycle after each pop; is_quiescent returns to 1 when drained.

Source files
------------

// File: rtl/dart_pkg.sv
// ---------------------------------------------------------------------------
// dart_pkg
// Shared widths and flit field helpers for the DART router input unit.
//   Flit layout (FLIT_WIDTH = 36):
//     [35:26] timestamp (TS_WIDTH = 10)
//     [ 3: 0] virtual channel field (only the low LOG_NVCS bits are used)
// No ports (package).
// ---------------------------------------------------------------------------
package dart_pkg;

    localparam int TS_WIDTH    = 10;
    localparam int LAT_WIDTH   = 8;
    localparam int A_WIDTH     = 11;
    localparam int FLIT_WIDTH  = 36;

    localparam int FLIT_TS_LSB = 26;
    localparam int FLIT_TS_MSB = 35;
    localparam int MAX_VC_BITS = 4;

    typedef logic [FLIT_WIDTH-1:0] flit_t;
    typedef logic [TS_WIDTH-1:0]   ts_t;

    function automatic ts_t flit_ts(input flit_t f);
        return f[FLIT_TS_MSB:FLIT_TS_LSB];
    endfunction

    function automatic logic [MAX_VC_BITS-1:0] flit_vc(input flit_t f);
        return f[MAX_VC_BITS-1:0];
    endfunction

    function automatic flit_t update_flit_ts(input flit_t f, input ts_t ts);
        flit_t r;
        r = f;
        r[FLIT_TS_MSB:FLIT_TS_LSB] = ts;
        return r;
    endfunction

endpackage

// File: rtl/ram_fifo_slow.sv
// ---------------------------------------------------------------------------
// ram_fifo_slow
// Single-VC FIFO of 2**LOG_DEP entries with a combinational head read and a
// one-cycle blackout after every pop request, so a consumer that waits for
// "not blocked" issues at most one pop every two cycles.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   enable            global advance; gates pops and the blackout flag
//   write, write_data push (caller guarantees write only when not full)
//   read              pop request; ignored while empty
//   full, empty       occupancy flags
//   blocked           blackout flag, high the cycle after a pop request
//   data_out          head entry (undefined while empty)
// ---------------------------------------------------------------------------
module ram_fifo_slow #(
    parameter int WIDTH   = 36,
    parameter int LOG_DEP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             write,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read,
    output logic             full,
    output logic             empty,
    output logic             blocked,
    output logic [WIDTH-1:0] data_out
);

    localparam int DEPTH = 1 << LOG_DEP;
    localparam logic [LOG_DEP:0] DEPTH_CNT = (LOG_DEP+1)'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [LOG_DEP-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEP-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEP:0]   count_q, count_d;
    logic               blk_q, blk_d;
    logic               push, pop;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign blocked  = blk_q;
    assign data_out = mem_q[rd_ptr_q];

    // The full gate makes an overflow impossible even if a caller misbehaves.
    assign push = write & ~full;
    assign pop  = enable & read & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Blackout follows the request, not the actual pop.
        blk_d    = enable & read;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            blk_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            blk_q    <= blk_d;
        end
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= write_data;
    end

endmodule

// File: rtl/flit_queue_nc.sv
// ---------------------------------------------------------------------------
// flit_queue_nc
// Router input unit: accepts flits addressed to HADDR, stamps each with
// arrival time (timestamp + latency), stores them per VC and presents a VC
// head once sim_time has reached its stamped time.
// Optional trace: define FLIT_QUEUE_TRACE_EN to print enqueue/dequeue events.
// Ports:
//   clock, reset               clock, synchronous active-high reset
//   enable                     global advance for enqueue/dequeue
//   sim_time                   current simulation time
//   error                      protocol violation (combinational)
//   is_quiescent               all VC FIFOs empty
//   latency                    configured link latency
//   config_in/_valid           daisy-chain config input
//   config_out/_valid          registered daisy-chain forward
//   flit_full                  per-VC full
//   flit_in_valid, flit_in     incoming flit
//   nexthop_in                 destination queue address of the flit
//   flit_ack                   flit accepted this cycle
//   flit_out, flit_out_valid   per-VC head flit and ready
//   dequeue                    per-VC pop
// Handshake: a flit transfers in on a cycle where flit_in_valid & flit_ack;
// a VC head transfers out when the consumer raises dequeue[v] while
// flit_out_valid[v] is high (enable must also be high for either).
// ---------------------------------------------------------------------------
module flit_queue_nc
    import dart_pkg::*;
#(
    parameter logic [A_WIDTH-1:0] HADDR    = 11'd1,
    parameter int                 LOG_NVCS = 1,
    parameter int                 LOG_DEP  = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [TS_WIDTH-1:0]              sim_time,
    output logic                             error,
    output logic                             is_quiescent,
    output logic [LAT_WIDTH-1:0]             latency,
    input  logic [15:0]                      config_in,
    input  logic                             config_in_valid,
    output logic [15:0]                      config_out,
    output logic                             config_out_valid,
    output logic [(1<<LOG_NVCS)-1:0]         flit_full,
    input  logic                             flit_in_valid,
    input  logic [FLIT_WIDTH-1:0]            flit_in,
    input  logic [A_WIDTH-1:0]               nexthop_in,
    output logic                             flit_ack,
    output logic [(1<<LOG_NVCS)*FLIT_WIDTH-1:0] flit_out,
    output logic [(1<<LOG_NVCS)-1:0]         flit_out_valid,
    input  logic [(1<<LOG_NVCS)-1:0]         dequeue
);

    localparam int NVCS = 1 << LOG_NVCS;

    logic [LAT_WIDTH-1:0] latency_q;
    logic [15:0]          config_out_q;
    logic                 config_out_valid_q;

    logic [LOG_NVCS-1:0]  in_vc;
    logic                 match;
    flit_t                stamped;
    logic [NVCS-1:0]      empty_v;
    logic [NVCS-1:0]      blk_v;
    flit_t                head [NVCS];

    assign latency          = latency_q;
    assign config_out       = config_out_q;
    assign config_out_valid = config_out_valid_q;

    // Shift-chain config: the new word replaces latency, the old one moves on.
    always_ff @(posedge clock) begin
        if (reset) begin
            latency_q          <= '0;
            config_out_q       <= '0;
            config_out_valid_q <= 1'b0;
        end else if (config_in_valid) begin
            latency_q          <= config_in[LAT_WIDTH-1:0];
            config_out_q       <= {8'b0, latency_q};
            config_out_valid_q <= 1'b1;
        end else begin
            config_out_valid_q <= 1'b0;
        end
    end

    assign in_vc    = flit_in[LOG_NVCS-1:0];
    assign match    = (nexthop_in == HADDR);
    assign flit_ack = enable & flit_in_valid & match & ~flit_full[in_vc];
    // Arrival stamp wraps modulo 2**TS_WIDTH.
    assign stamped  = update_flit_ts(flit_in, flit_ts(flit_in) + TS_WIDTH'(latency_q));

    for (genvar v = 0; v < NVCS; v++) begin : g_vc
        ts_t age;

        ram_fifo_slow #(
            .WIDTH   (FLIT_WIDTH),
            .LOG_DEP (LOG_DEP)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .write      (flit_ack & (in_vc == LOG_NVCS'(v))),
            .write_data (stamped),
            .read       (dequeue[v]),
            .full       (flit_full[v]),
            .empty      (empty_v[v]),
            .blocked    (blk_v[v]),
            .data_out   (head[v])
        );

        // Wrap-safe "time reached": elapsed time in the lower half of the ring.
        assign age = sim_time - flit_ts(head[v]);
        assign flit_out_valid[v] = ~empty_v[v] & ~blk_v[v] & (age < ts_t'(512));
        assign flit_out[v*FLIT_WIDTH +: FLIT_WIDTH] = head[v];
    end

    always_comb begin
        error = 1'b0;
        for (int v = 0; v < NVCS; v++) begin
            if (flit_in_valid & match & (in_vc == LOG_NVCS'(v)) & flit_full[v])
                error = 1'b1;
            if (dequeue[v] & empty_v[v])
                error = 1'b1;
        end
    end

    assign is_quiescent = &empty_v;

`ifdef FLIT_QUEUE_TRACE_EN
    always @(posedge clock) begin
        if (!reset) begin
            if (flit_ack)
                $display("T %0d FQ (%0d) enq vc %0d flit %h", sim_time, HADDR, in_vc, stamped);
            for (int v = 0; v < NVCS; v++) begin
                if (enable & dequeue[v] & ~empty_v[v])
                    $display("T %0d FQ (%0d) deq vc %0d", sim_time, HADDR, v);
            end
        end
    end
`endif

endmodule

// File: tb/tb_flit_queue_nc.sv
// ---------------------------------------------------------------------------
// tb_flit_queue_nc
// Directed bench for flit_queue_nc (HADDR=1, two VCs, depth 16) with a
// per-VC expected-flit queue.
// ---------------------------------------------------------------------------
module tb_flit_queue_nc;
    import dart_pkg::*;

    localparam logic [A_WIDTH-1:0] HADDR = 11'd1;
    localparam int LOG_NVCS = 1;
    localparam int NVCS     = 2;

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic                       enable = 1'b0;
    logic [TS_WIDTH-1:0]        sim_time = '0;
    logic                       error;
    logic                       is_quiescent;
    logic [LAT_WIDTH-1:0]       latency;
    logic [15:0]                config_in = '0;
    logic                       config_in_valid = 1'b0;
    logic [15:0]                config_out;
    logic                       config_out_valid;
    logic [NVCS-1:0]            flit_full;
    logic                       flit_in_valid = 1'b0;
    logic [FLIT_WIDTH-1:0]      flit_in = '0;
    logic [A_WIDTH-1:0]         nexthop_in = '0;
    logic                       flit_ack;
    logic [NVCS*FLIT_WIDTH-1:0] flit_out;
    logic [NVCS-1:0]            flit_out_valid;
    logic [NVCS-1:0]            dequeue = '0;

    int checks = 0;
    int errors = 0;
    logic [LAT_WIDTH-1:0]  lat_model = '0;
    logic [FLIT_WIDTH-1:0] exp_q0[$];
    logic [FLIT_WIDTH-1:0] exp_q1[$];

    flit_queue_nc #(
        .HADDR    (HADDR),
        .LOG_NVCS (LOG_NVCS),
        .LOG_DEP  (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .sim_time         (sim_time),
        .error            (error),
        .is_quiescent     (is_quiescent),
        .latency          (latency),
        .config_in        (config_in),
        .config_in_valid  (config_in_valid),
        .config_out       (config_out),
        .config_out_valid (config_out_valid),
        .flit_full        (flit_full),
        .flit_in_valid    (flit_in_valid),
        .flit_in          (flit_in),
        .nexthop_in       (nexthop_in),
        .flit_ack         (flit_ack),
        .flit_out         (flit_out),
        .flit_out_valid   (flit_out_valid),
        .dequeue          (dequeue)
    );

    // clock/reset
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drivers
    function automatic logic [FLIT_WIDTH-1:0] make_flit(input logic [TS_WIDTH-1:0] ts,
                                                        input logic vc);
        logic [FLIT_WIDTH-1:0] f;
        f = {ts, 26'($urandom_range(0, 32'h3ff_ffff))};
        f[0] = vc;
        return f;
    endfunction

    // Reference stamp: ts field + latency mod 1024, payload untouched.
    function automatic logic [FLIT_WIDTH-1:0] stamp(input logic [FLIT_WIDTH-1:0] f);
        logic [FLIT_WIDTH-1:0] r;
        logic [TS_WIDTH-1:0]   t;
        r = f;
        t = f[35:26] + {2'b00, lat_model};
        r[35:26] = t;
        return r;
    endfunction

    task automatic send_config(input logic [15:0] w);
        config_in       = w;
        config_in_valid = 1'b1;
        tick();
        config_in_valid = 1'b0;
        lat_model = w[7:0];
    endtask

    initial begin : main
        int n;
        logic [FLIT_WIDTH-1:0] f;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        #2;
        check("rst_full", flit_full, 2'b00);
        check("rst_valid", flit_out_valid, 2'b00);
        check("rst_quiescent", is_quiescent, 1);
        check("rst_latency", latency, 0);
        check("rst_cfg_out", config_out, 0);
        check("rst_cfg_valid", config_out_valid, 0);
        check("rst_error", error, 0);

        // Config shift chain
        send_config(16'h0005);
        check("cfg1_latency", latency, 5);
        check("cfg1_out", config_out, 16'h0000);
        check("cfg1_valid", config_out_valid, 1);
        send_config(16'h0009);
        check("cfg2_latency", latency, 9);
        check("cfg2_out", config_out, 16'h0005);
        tick();
        check("cfg_valid_drop", config_out_valid, 0);
        check("cfg_out_hold", config_out, 16'h0005);
        send_config(16'h0005);
        check("cfg3_out", config_out, 16'h0009);

        // Single flit with latency 5 on VC1
        enable     = 1'b1;
        sim_time   = 10'd10;
        nexthop_in = HADDR;
        f = make_flit(10'd10, 1'b1);
        flit_in = f;
        flit_in_valid = 1'b1;
        #2;
        check("ack_vc1", flit_ack, 1);
        check("err_vc1", error, 0);
        exp_q1.push_back(stamp(f));
        tick();
        flit_in_valid = 1'b0;
        #2;
        check("vc1_not_yet_10", flit_out_valid[1], 0);
        check("vc1_quiescent", is_quiescent, 0);
        sim_time = 10'd14;
        #1;
        check("vc1_not_yet_14", flit_out_valid[1], 0);
        sim_time = 10'd15;
        #1;
        check("vc1_ready_15", flit_out_valid[1], 1);
        check("vc1_ts_15", flit_out[71:62], 10'd15);
        check("vc1_data", flit_out[71:36], exp_q1[0]);
        dequeue = 2'b10;
        #1;
        check("vc1_pop_err", error, 0);
        tick();
        void'(exp_q1.pop_front());
        dequeue = 2'b00;
        #2;
        check("vc1_drained", is_quiescent, 1);
        check("vc1_valid_gone", flit_out_valid, 2'b00);

        // Address mismatch
        nexthop_in = 11'd2;
        flit_in = make_flit(10'd3, 1'b0);
        flit_in_valid = 1'b1;
        #2;
        check("miss_ack", flit_ack, 0);
        check("miss_err", error, 0);
        tick();
        flit_in_valid = 1'b0;
        nexthop_in = HADDR;
        #2;
        check("miss_quiescent", is_quiescent, 1);

        // Fill VC0
        sim_time = 10'd100;
        for (int i = 0; i < 16; i++) begin
            f = make_flit(10'(80 + $urandom_range(0, 15)), 1'b0);
            flit_in = f;
            flit_in_valid = 1'b1;
            #2;
            check("fill_ack", flit_ack, 1);
            exp_q0.push_back(stamp(f));
            tick();
        end
        flit_in = make_flit(10'd90, 1'b0);
        #2;
        check("full_flags", flit_full, 2'b01);
        check("overflow_ack", flit_ack, 0);
        check("overflow_err", error, 1);
        tick();
        flit_in_valid = 1'b0;
        #2;
        check("still_full", flit_full, 2'b01);

        // Drain VC0: pop, idle, pop ... with a push while full and one mid-drain
        n = 0;
        while (exp_q0.size() > 0 && n < 40) begin
            #1;
            check("drain_valid", flit_out_valid[0], 1);
            check("drain_data", flit_out[35:0], exp_q0[0]);
            dequeue = 2'b01;
            if (n == 0) begin
                flit_in = make_flit(10'd90, 1'b0);
                flit_in_valid = 1'b1;
                #1;
                check("full_pop_ack", flit_ack, 0);
                check("full_pop_err", error, 1);
            end else if (n == 3) begin
                f = make_flit(10'd90, 1'b0);
                flit_in = f;
                flit_in_valid = 1'b1;
                #1;
                check("pushpop_ack", flit_ack, 1);
                check("pushpop_err", error, 0);
                exp_q0.push_back(stamp(f));
            end
            tick();
            void'(exp_q0.pop_front());
            dequeue = 2'b00;
            flit_in_valid = 1'b0;
            #2;
            check("blackout", flit_out_valid[0], 0);
            if (n == 0) check("unfull_after_pop", flit_full[0], 0);
            tick();
            n++;
        end
        check("drain_done", exp_q0.size(), 0);
        check("drain_quiescent", is_quiescent, 1);

        // Timestamp wrap with latency 10
        send_config(16'h000A);
        check("cfg4_out", config_out, 16'h0005);
        sim_time = 10'd1022;
        f = make_flit(10'd1020, 1'b1);
        flit_in = f;
        flit_in_valid = 1'b1;
        #2;
        check("wrap_ack", flit_ack, 1);
        exp_q1.push_back(stamp(f));
        tick();
        flit_in_valid = 1'b0;
        #2;
        check("wrap_ts", flit_out[71:62], 10'd6);
        check("wrap_1022", flit_out_valid[1], 0);
        sim_time = 10'd5;
        #1;
        check("wrap_5", flit_out_valid[1], 0);
        sim_time = 10'd6;
        #1;
        check("wrap_6", flit_out_valid[1], 1);
        check("wrap_data", flit_out[71:36], exp_q1[0]);
        dequeue = 2'b10;
        tick();
        void'(exp_q1.pop_front());
        dequeue = 2'b00;
        #2;
        check("wrap_drained", is_quiescent, 1);

        // Illegal pop on empty VC0
        dequeue = 2'b01;
        #1;
        check("empty_pop_err", error, 1);
        tick();
        dequeue = 2'b00;
        #2;
        check("empty_pop_quiescent", is_quiescent, 1);
        check("empty_pop_full", flit_full, 2'b00);

        // enable low: no accept, config still runs
        enable = 1'b0;
        flit_in = make_flit(10'd6, 1'b0);
        flit_in_valid = 1'b1;
        config_in = 16'h0003;
        config_in_valid = 1'b1;
        #2;
        check("dis_ack", flit_ack, 0);
        check("dis_err", error, 0);
        tick();
        config_in_valid = 1'b0;
        flit_in_valid = 1'b0;
        lat_model = 8'd3;
        #2;
        check("dis_latency", latency, 3);
        check("dis_cfg_out", config_out, 16'h000A);
        check("dis_quiescent", is_quiescent, 1);

        // Reset mid-operation discards queued flits
        enable = 1'b1;
        flit_in = make_flit(10'd6, 1'b0);
        flit_in_valid = 1'b1;
        #2;
        check("pre_rst_ack", flit_ack, 1);
        tick();
        flit_in_valid = 1'b0;
        #1;
        check("pre_rst_busy", is_quiescent, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lat_model = '0;
        #2;
        check("mid_rst_quiescent", is_quiescent, 1);
        check("mid_rst_valid", flit_out_valid, 2'b00);
        check("mid_rst_latency", latency, 0);
        check("mid_rst_cfg_out", config_out, 0);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
